rx_uart: RTL and testbench
==========================

// Module: rx_uart
// PURPOSE
//  UART receiver: the counterpart of tx_uart on the host debug link. Oversamples the serial line on the
//  shared BaudRateGenerator tick and deframes 8N1 characters. Buffers received bytes in a small FIFO
//  whose output feeds debug_unit (din/empty), so no byte is lost while the debug FSM is busy.
// PARAMETERS
//  N_BITS      8   data bits per frame
//  OS_TICK     16  s_tick pulses per bit period (oversampling ratio)
//  SB_TICK     16  s_tick pulses sampled for the stop bit
//  FIFO_AW     2   FIFO address width; depth = 2**FIFO_AW = 4 bytes
// PORTS
//  clock         in   1       system clock
//  reset         in   1       asynchronous reset, active-low
//  s_tick        in   1       oversample strobe, one clock cycle wide
//  rx            in   1       serial input, idle high, asynchronous to clock
//  rd_i          in   1       pop request; ignored when empty_o=1
//  dout_o        out  N_BITS  FIFO head byte (first-word fall-through)
//  empty_o       out  1       FIFO empty
//  full_o        out  1       FIFO full
//  rx_done_tick  out  1       1-cycle pulse when a valid frame is written to the FIFO
//  framing_err   out  1       1-cycle pulse: stop bit sampled low
//  overrun_err   out  1       1-cycle pulse: valid frame dropped because the FIFO is full
//  parity_err    out  1       1-cycle pulse: parity mismatch (see CONFIGURATION)
// BEHAVIOUR
//  - rx passes through a 2-flop synchronizer (both flops reset to 1); the FSM sees only rx_s.
//  - Reset values: dout_o=0, empty_o=1, full_o=0, all pulse outputs=0, FSM=IDLE, counters=0,
//    FIFO pointers=0. Reset mid-frame abandons the frame and flushes the FIFO.
//  - Counters advance only when s_tick=1. s_cnt is 4 bits; n_cnt counts 0..N_BITS-1.
//  - IDLE: rx_s=0 -> START with s_cnt=0.
//  - START: at s_cnt==OS_TICK/2-1 (mid start bit): if rx_s=0 -> DATA with s_cnt=0, n_cnt=0;
//    if rx_s=1 -> IDLE (glitch rejected, no error reported).
//  - DATA: at s_cnt==OS_TICK-1, sample rx_s LSB-first (shift right, new bit enters at MSB) and set s_cnt=0;
//    after bit N_BITS-1 -> PARITY if RX_PARITY_EN is defined, otherwise -> STOP.
//  - PARITY: at s_cnt==OS_TICK-1, sample the parity bit -> STOP.
//  - STOP: at s_cnt==SB_TICK-1:
//      * rx_s=1 and no parity fault -> push the byte, then IDLE.
//      * rx_s=0 -> pulse framing_err, discard the byte, go to BREAK.
//      * parity fault -> pulse parity_err, discard the byte, then IDLE.
//  - BREAK: wait for rx_s=1, then IDLE. A held-low line produces exactly one framing_err.
//  - Push latency: rx_done_tick and the FIFO write occur in the cycle after the stop-bit sample.
//    empty_o deasserts and dout_o is valid in the following cycle.
//  - FIFO push when full, without a pop in the same cycle: overrun_err pulses, the byte is dropped,
//    contents are unchanged, and rx_done_tick stays 0.
//  - Push and pop in the same cycle: always legal. When full, the pop frees a slot and the push succeeds
//    (no overrun). When empty, only the push takes effect.
//  - Pointers are FIFO_AW+1 bits and wrap modulo 2**(FIFO_AW+1); full/empty come from the MSB comparison.
//  - At most one of rx_done_tick, framing_err, parity_err, overrun_err is asserted per cycle.
// CONFIGURATION
//  RX_PARITY_EN defined: frame is 8E1 (even parity). The PARITY state exists; a mismatch pulses
//    parity_err and drops the byte.
//  RX_PARITY_EN undefined: frame is 8N1. The PARITY state is not compiled in; parity_err is tied to 0.
// STRUCTURE
//  uart_pkg (shared with tx_uart): FSM state encodings (IDLE, START, DATA, PARITY, STOP, BREAK),
//    default N_BITS/OS_TICK/SB_TICK, and a function for the even-parity reduction.
//  Sub-module rx_fifo: parameterised FWFT synchronous FIFO (FIFO_AW, N_BITS) with the same clock/reset.
//  rx_uart holds the synchronizer, FSM, counters, shift register and error pulses.
// TESTING (16x tick, 8N1 unless noted)
//  1. Send 0xA5 cleanly -> one rx_done_tick; dout_o=0xA5 and empty_o=0 the cycle after; rd_i=1 -> empty_o=1.
//  2. Send 0x00, 0xFF, 0x55, 0x3C, 0x81 with no reads -> first four bytes stored, full_o=1;
//     fifth byte -> overrun_err pulse; reads return 00,FF,55,3C.
//  3. FIFO full; pulse rd_i in the same cycle as the 5th push -> no overrun_err, reads return FF,55,3C,81.
//  4. Send 0x12 with stop bit forced low, then hold rx low for 40 bit times -> exactly one framing_err,
//    nothing pushed; release rx, send 0x34 -> received 0x34.
//  5. Drive a 0.25-bit low glitch on idle rx -> no pulse on any output, FSM back to IDLE.
//     Assert reset during DATA of 0x77 -> empty_o=1, no push; the next 0x77 is received.
//  6. RX_PARITY_EN defined: 0x03 with parity bit 0 -> pushed; 0x03 with parity bit 1 -> parity_err, not pushed.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encodings, default frame geometry and
// the even-parity reduction used by both the receiver and the transmitter.
package uart_pkg;

   localparam int N_BITS_DEF  = 8;
   localparam int OS_TICK_DEF = 16;
   localparam int SB_TICK_DEF = 16;
   localparam int PAR_W       = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_t;

   // Parity bit that makes the total count of ones even; callers zero-extend.
   function automatic logic even_parity(input logic [PAR_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through synchronous FIFO for received bytes. A write is
// accepted when not full, or when full and a pop frees the slot in the same cycle.
module rx_fifo #(
   parameter int FIFO_AW = 2,
   parameter int N_BITS  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr,
   input  logic [N_BITS-1:0] wdata,
   input  logic              rd,
   output logic [N_BITS-1:0] rdata,
   output logic              empty,
   output logic              full
);

   localparam int DEPTH = 2 ** FIFO_AW;

   logic [N_BITS-1:0] mem [DEPTH];
   logic [FIFO_AW:0]  wr_ptr;
   logic [FIFO_AW:0]  rd_ptr;
   logic              rd_en;
   logic              wr_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

   assign rd_en = rd & ~empty;
   assign wr_en = wr & (~full | rd_en);

   assign rdata = mem[rd_ptr[FIFO_AW-1:0]];

   // Storage is reset so the head reads zero after a flush.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= wdata;
            wr_ptr                   <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/rx_uart.sv
// UART receiver: oversampled 8N1 deframer feeding a small FWFT byte FIFO.
// Define RX_PARITY_EN to receive 8E1 frames with parity checking.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | line idle, waiting for a falling edge on rx_s
// START    | counting to the middle of the start bit, glitch check
// DATA     | sampling N_BITS data bits LSB-first at mid-bit
// PARITY   | sampling the even-parity bit (RX_PARITY_EN only)
// STOP     | sampling the stop bit, deciding push / error
// BREAK    | line held low after a framing error, wait for idle
module rx_uart
   import uart_pkg::*;
#(
   parameter int N_BITS  = N_BITS_DEF,
   parameter int OS_TICK = OS_TICK_DEF,
   parameter int SB_TICK = SB_TICK_DEF,
   parameter int FIFO_AW = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              s_tick,
   input  logic              rx,
   input  logic              rd_i,
   output logic [N_BITS-1:0] dout_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              rx_done_tick,
   output logic              framing_err,
   output logic              overrun_err,
   output logic              parity_err
);

   localparam int NW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

   logic              rx_meta;
   logic              rx_s;

   rx_state_t         state;
   rx_state_t         state_nx;
   logic [3:0]        s_cnt;
   logic [3:0]        s_cnt_nx;
   logic [NW-1:0]     n_cnt;
   logic [NW-1:0]     n_cnt_nx;
   logic [N_BITS-1:0] b_reg;
   logic [N_BITS-1:0] b_nx;
   logic              push_pend;
   logic              push_nx;
   logic              ferr_q;
   logic              ferr_nx;
   logic              par_bad;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

`ifdef RX_PARITY_EN
   logic p_reg;
   logic p_nx;
   logic perr_q;
   logic perr_nx;

   assign par_bad = even_parity(PAR_W'(b_reg)) ^ p_reg;
`else
   assign par_bad = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         s_cnt     <= '0;
         n_cnt     <= '0;
         b_reg     <= '0;
         push_pend <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state     <= state_nx;
         s_cnt     <= s_cnt_nx;
         n_cnt     <= n_cnt_nx;
         b_reg     <= b_nx;
         push_pend <= push_nx;
         ferr_q    <= ferr_nx;
      end
   end

`ifdef RX_PARITY_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         p_reg  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         p_reg  <= p_nx;
         perr_q <= perr_nx;
      end
   end
`endif

   always_comb begin
      state_nx = state;
      s_cnt_nx = s_cnt;
      n_cnt_nx = n_cnt;
      b_nx     = b_reg;
      push_nx  = 1'b0;
      ferr_nx  = 1'b0;
`ifdef RX_PARITY_EN
      p_nx     = p_reg;
      perr_nx  = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (!rx_s) begin
               state_nx = ST_START;
               s_cnt_nx = '0;
            end
         end
         ST_START: begin
            if (s_tick) begin
               if (s_cnt == 4'(OS_TICK/2 - 1)) begin
                  if (!rx_s) begin
                     state_nx = ST_DATA;
                     s_cnt_nx = '0;
                     n_cnt_nx = '0;
                  end else begin
                     state_nx = ST_IDLE;
                  end
               end else begin
                  s_cnt_nx = s_cnt + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (s_tick) begin
               if (s_cnt == 4'(OS_TICK - 1)) begin
                  s_cnt_nx = '0;
                  b_nx     = {rx_s, b_reg[N_BITS-1:1]};
                  if (n_cnt == NW'(N_BITS - 1)) begin
`ifdef RX_PARITY_EN
                     state_nx = ST_PARITY;
`else
                     state_nx = ST_STOP;
`endif
                  end else begin
                     n_cnt_nx = n_cnt + 1'b1;
                  end
               end else begin
                  s_cnt_nx = s_cnt + 4'd1;
               end
            end
         end
`ifdef RX_PARITY_EN
         ST_PARITY: begin
            if (s_tick) begin
               if (s_cnt == 4'(OS_TICK - 1)) begin
                  s_cnt_nx = '0;
                  p_nx     = rx_s;
                  state_nx = ST_STOP;
               end else begin
                  s_cnt_nx = s_cnt + 4'd1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (s_tick) begin
               if (s_cnt == 4'(SB_TICK - 1)) begin
                  s_cnt_nx = '0;
                  if (!rx_s) begin
                     ferr_nx  = 1'b1;
                     state_nx = ST_BREAK;
                  end else if (par_bad) begin
`ifdef RX_PARITY_EN
                     perr_nx  = 1'b1;
`endif
                     state_nx = ST_IDLE;
                  end else begin
                     push_nx  = 1'b1;
                     state_nx = ST_IDLE;
                  end
               end else begin
                  s_cnt_nx = s_cnt + 4'd1;
               end
            end
         end
         ST_BREAK: begin
            if (rx_s) begin
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // A full FIFO still accepts the byte when the consumer pops in the same cycle.
   assign rx_done_tick = push_pend & (~full_o | rd_i);
   assign overrun_err  = push_pend & full_o & ~rd_i;
   assign framing_err  = ferr_q;
`ifdef RX_PARITY_EN
   assign parity_err   = perr_q;
`else
   assign parity_err   = 1'b0;
`endif

   rx_fifo #(
      .FIFO_AW (FIFO_AW),
      .N_BITS  (N_BITS)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .wr    (push_pend),
      .wdata (b_reg),
      .rd    (rd_i),
      .rdata (dout_o),
      .empty (empty_o),
      .full  (full_o)
   );

endmodule

// File: tb/tb_rx_uart.sv
// Bench for rx_uart: serial frames in, scoreboard of expected FIFO bytes out.
// Build with RX_PARITY_EN defined to add the 8E1 parity cases.
module tb_rx_uart;

   localparam int BIT_CLK = 64;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       s_tick = 1'b0;
   logic       rx = 1'b1;
   logic       rd_i = 1'b0;
   logic [7:0] dout_o;
   logic       empty_o;
   logic       full_o;
   logic       rx_done_tick;
   logic       framing_err;
   logic       overrun_err;
   logic       parity_err;

   logic [1:0] tdiv = 2'd0;

   int checks = 0;
   int errors = 0;

   logic [7:0] sb[$];

   int   done_cnt = 0;
   int   ferr_cnt = 0;
   int   oerr_cnt = 0;
   int   perr_cnt = 0;
   logic done_d = 1'b0;

   rx_uart dut (
      .clock        (clock),
      .reset        (reset),
      .s_tick       (s_tick),
      .rx           (rx),
      .rd_i         (rd_i),
      .dout_o       (dout_o),
      .empty_o      (empty_o),
      .full_o       (full_o),
      .rx_done_tick (rx_done_tick),
      .framing_err  (framing_err),
      .overrun_err  (overrun_err),
      .parity_err   (parity_err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      tdiv   <= tdiv + 2'd1;
      s_tick <= (tdiv == 2'd3);
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      if (done_d) check_val("empty_after_push", 32'(empty_o), 32'd0);
      done_d = rx_done_tick;
      if (rx_done_tick | framing_err | overrun_err | parity_err) begin
         check_val("pulse_onehot",
                   32'(rx_done_tick) + 32'(framing_err) + 32'(overrun_err) + 32'(parity_err), 32'd1);
         if (rx_done_tick) done_cnt++;
         if (framing_err)  ferr_cnt++;
         if (overrun_err)  oerr_cnt++;
         if (parity_err)   perr_cnt++;
      end
   end

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT_CLK) @(posedge clock);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef RX_PARITY_EN
      drive_bit((^d) ^ par_flip);
`else
      if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
      drive_bit(stop);
      rx = 1'b1;
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] exp;
      @(negedge clock);
      if (sb.size() == 0) begin
         check_val({tag, "_empty"}, 32'(empty_o), 32'd1);
         return;
      end
      exp = sb.pop_front();
      check_val({tag, "_nonempty"}, 32'(empty_o), 32'd0);
      check_val(tag, 32'(dout_o), 32'(exp));
      rd_i = 1'b1;
      @(posedge clock);
      #1 rd_i = 1'b0;
   endtask

   task automatic settle();
      repeat (8) @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: observed timeout expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0, f0, o0, p0;
      logic [7:0] fill [4];
      fill[0] = 8'h00; fill[1] = 8'hFF; fill[2] = 8'h55; fill[3] = 8'h3C;

      repeat (5) @(posedge clock);
      @(negedge clock);
      check_val("rst_empty", 32'(empty_o), 32'd1);
      check_val("rst_full",  32'(full_o),  32'd0);
      check_val("rst_dout",  32'(dout_o),  32'd0);
      check_val("rst_pulses", 32'({rx_done_tick, framing_err, overrun_err, parity_err}), 32'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (BIT_CLK) @(posedge clock);

      // 1: single clean byte
      d0 = done_cnt;
      sb.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0);
      settle();
      check_val("t1_done", 32'(done_cnt - d0), 32'd1);
      pop_check("t1_byte");
      @(negedge clock);
      check_val("t1_empty_after_rd", 32'(empty_o), 32'd1);

      // 2: fill, then overrun
      d0 = done_cnt; o0 = oerr_cnt;
      for (int i = 0; i < 4; i++) begin
         sb.push_back(fill[i]);
         send_frame(fill[i], 1'b1, 1'b0);
      end
      settle();
      check_val("t2_full", 32'(full_o), 32'd1);
      send_frame(8'h81, 1'b1, 1'b0);
      settle();
      check_val("t2_overrun", 32'(oerr_cnt - o0), 32'd1);
      check_val("t2_done", 32'(done_cnt - d0), 32'd4);
      check_val("t2_still_full", 32'(full_o), 32'd1);
      for (int i = 0; i < 4; i++) pop_check("t2_byte");
      @(negedge clock);
      check_val("t2_empty", 32'(empty_o), 32'd1);

      // 3: pop in the same cycle as the push into a full FIFO
      d0 = done_cnt; o0 = oerr_cnt;
      for (int i = 0; i < 4; i++) begin
         sb.push_back(fill[i]);
         send_frame(fill[i], 1'b1, 1'b0);
      end
      fork
         send_frame(8'h81, 1'b1, 1'b0);
         begin
            for (int n = 0; n < 2000 && !overrun_err; n++) begin
               @(posedge clock);
               #1;
            end
            check_val("t3_push_seen", 32'(overrun_err), 32'd1);
            check_val("t3_head", 32'(dout_o), 32'(sb.pop_front()));
            rd_i = 1'b1;
            sb.push_back(8'h81);
            @(posedge clock);
            #1 rd_i = 1'b0;
         end
      join
      settle();
      check_val("t3_no_overrun", 32'(oerr_cnt - o0), 32'd0);
      check_val("t3_done", 32'(done_cnt - d0), 32'd5);
      check_val("t3_full", 32'(full_o), 32'd1);
      for (int i = 0; i < 4; i++) pop_check("t3_byte");

      // 4: framing error followed by a long break
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(8'h12, 1'b0, 1'b0);
      rx = 1'b0;
      repeat (40 * BIT_CLK) @(posedge clock);
      rx = 1'b1;
      repeat (2 * BIT_CLK) @(posedge clock);
      @(negedge clock);
      check_val("t4_ferr", 32'(ferr_cnt - f0), 32'd1);
      check_val("t4_no_push", 32'(done_cnt - d0), 32'd0);
      check_val("t4_empty", 32'(empty_o), 32'd1);
      sb.push_back(8'h34);
      send_frame(8'h34, 1'b1, 1'b0);
      settle();
      check_val("t4_done", 32'(done_cnt - d0), 32'd1);
      pop_check("t4_byte");

      // 5: start-bit glitch, then reset during data
      d0 = done_cnt; f0 = ferr_cnt; o0 = oerr_cnt; p0 = perr_cnt;
      rx = 1'b0;
      repeat (BIT_CLK / 4) @(posedge clock);
      rx = 1'b1;
      repeat (2 * BIT_CLK) @(posedge clock);
      @(negedge clock);
      check_val("t5_glitch_pulses",
                32'((done_cnt - d0) + (ferr_cnt - f0) + (oerr_cnt - o0) + (perr_cnt - p0)), 32'd0);
      check_val("t5_glitch_empty", 32'(empty_o), 32'd1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b1);
      reset = 1'b0;
      rx    = 1'b1;
      repeat (4) @(posedge clock);
      @(negedge clock);
      check_val("t5_rst_empty", 32'(empty_o), 32'd1);
      check_val("t5_rst_dout", 32'(dout_o), 32'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (2 * BIT_CLK) @(posedge clock);
      @(negedge clock);
      check_val("t5_rst_no_push", 32'(done_cnt - d0), 32'd0);
      sb.push_back(8'h77);
      send_frame(8'h77, 1'b1, 1'b0);
      settle();
      check_val("t5_done", 32'(done_cnt - d0), 32'd1);
      pop_check("t5_byte");

`ifdef RX_PARITY_EN
      // 6: good and bad even parity
      d0 = done_cnt; p0 = perr_cnt;
      sb.push_back(8'h03);
      send_frame(8'h03, 1'b1, 1'b0);
      send_frame(8'h03, 1'b1, 1'b1);
      settle();
      check_val("t6_perr", 32'(perr_cnt - p0), 32'd1);
      check_val("t6_done", 32'(done_cnt - d0), 32'd1);
      pop_check("t6_byte");
      @(negedge clock);
      check_val("t6_empty", 32'(empty_o), 32'd1);
`else
      @(negedge clock);
      check_val("parity_tied_low", 32'(perr_cnt), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
